// File: rtl/cpu_di_pkg.sv
// Shared types and constants for the CPU data-in arbiter.
package cpu_di_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    // Z80 NOP, driven onto the data-in bus after reset
    localparam logic [7:0] NOP_DATA = 8'h00;

    // Width of the saturating collision counter
    localparam int unsigned COLL_CNT_W = 16;

    // Index width for n sources (never narrower than one bit)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_di_prio_enc.sv
// Lowest-index priority encoder with "more than one request" detect.
module cpu_di_prio_enc
    import cpu_di_pkg::*;
#(
    parameter int unsigned N  = 10,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic          multi
);

    // Scan upward: first set bit wins, a second set bit flags multi
    always_comb begin
        any   = 1'b0;
        idx   = '0;
        multi = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    idx = IW'(i);
                end
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_di_arbiter.sv
// CPU data-in arbiter: fixed-priority source select with transaction lock,
// per-source wait states via cpu_ready, and select-collision detection.
// Optional macro CPU_DI_COLL_CNT_EN adds the 16-bit saturating coll_count.
module cpu_di_arbiter
    import cpu_di_pkg::*;
#(
    parameter int unsigned         NUM_SRC   = 10,
    parameter int unsigned         DATA_W    = 8,
    parameter int unsigned         WAIT_W    = 3,
    parameter logic [DATA_W-1:0]   IDLE_DATA = DATA_W'(NOP_DATA)
) (
    input  logic                         pll0_250MHz,
    input  logic                         reset,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    input  logic [NUM_SRC-1:0]           src_cs,
    input  logic [NUM_SRC*WAIT_W-1:0]    src_wait,
    input  logic                         coll_clr,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    output logic                         cpu_ready,
    output logic [idx_w(NUM_SRC)-1:0]    active_idx,
    output logic                         collision
`ifdef CPU_DI_COLL_CNT_EN
    ,
    output logic [COLL_CNT_W-1:0]        coll_count
`endif
);

    localparam int unsigned IW = idx_w(NUM_SRC);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                coll_q, coll_d;
    logic                counted_q, counted_d;
`ifdef CPU_DI_COLL_CNT_EN
    logic [COLL_CNT_W-1:0] ccnt_q, ccnt_d;
`endif

    logic [DATA_W-1:0]   data_arr [NUM_SRC];
    logic [WAIT_W-1:0]   wait_arr [NUM_SRC];
    logic                enc_any, enc_multi;
    logic [IW-1:0]       enc_idx;
    logic                cs_locked;
    logic [NUM_SRC-1:0]  others;
    logic                coll_ev;

    cpu_di_prio_enc #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio_enc (
        .req   (src_cs),
        .any   (enc_any),
        .idx   (enc_idx),
        .multi (enc_multi)
    );

    // Unpack the flat source buses into per-source arrays
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            data_arr[i] = src_data[i*DATA_W +: DATA_W];
            wait_arr[i] = src_wait[i*WAIT_W +: WAIT_W];
        end
    end

    // Lock status and foreign selects relative to the locked source
    always_comb begin
        cs_locked = src_cs[idx_q];
        others    = src_cs & ~(NUM_SRC'(1) << idx_q);
        if (state_q == IDLE) begin
            coll_ev = enc_any & enc_multi;
        end else begin
            coll_ev = (|others) & ~counted_q;
        end
    end

    // State register
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d = (wait_arr[enc_idx] == '0) ? VALID : WAIT;
                end
            end
            WAIT: begin
                if (!cs_locked) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (!cs_locked) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and counters
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        counted_d = counted_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                if (enc_any) begin
                    idx_d     = enc_idx;
                    counted_d = enc_multi;
                    if (wait_arr[enc_idx] == '0) begin
                        data_d  = data_arr[enc_idx];
                        valid_d = 1'b1;
                    end else begin
                        cnt_d   = wait_arr[enc_idx];
                        ready_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (!cs_locked) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end else if (cnt_q == WAIT_W'(1)) begin
                    data_d  = data_arr[idx_q];
                    valid_d = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q - WAIT_W'(1);
                    ready_d = 1'b0;
                end
            end
            VALID: begin
                ready_d = 1'b1;
                if (cs_locked) begin
                    data_d  = data_arr[idx_q];
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
        if (state_q != IDLE && coll_ev) begin
            counted_d = 1'b1;
        end

        // A clear coinciding with an event leaves the event's effect
        coll_d = coll_clr ? coll_ev : (coll_q | coll_ev);
`ifdef CPU_DI_COLL_CNT_EN
        if (coll_clr) begin
            ccnt_d = coll_ev ? COLL_CNT_W'(1) : '0;
        end else if (coll_ev && ccnt_q != '1) begin
            ccnt_d = ccnt_q + COLL_CNT_W'(1);
        end else begin
            ccnt_d = ccnt_q;
        end
`endif
    end

    // Output and datapath registers
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            data_q    <= IDLE_DATA;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            idx_q     <= '0;
            cnt_q     <= '0;
            coll_q    <= 1'b0;
            counted_q <= 1'b0;
`ifdef CPU_DI_COLL_CNT_EN
            ccnt_q    <= '0;
`endif
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            coll_q    <= coll_d;
            counted_q <= counted_d;
`ifdef CPU_DI_COLL_CNT_EN
            ccnt_q    <= ccnt_d;
`endif
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign cpu_ready  = ready_q;
    assign active_idx = idx_q;
    assign collision  = coll_q;
`ifdef CPU_DI_COLL_CNT_EN
    assign coll_count = ccnt_q;
`endif

endmodule

// File: doc/cpu_di_arbiter.md
# cpu_di_arbiter

Parametrised successor to the Z80 data-input multiplexer. It selects one of `NUM_SRC` device data-out buses onto the registered CPU data-in bus using fixed priority. It then locks that source for the whole transaction and inserts per-source wait states through a ready handshake. It also flags and counts select collisions, because Efinix parts have no tri-states and overlapping selects are a decode bug.

## Interface
Parameters:
- `NUM_SRC`, 10, number of data sources; index 0 has highest priority.
- `DATA_W`, 8, data width.
- `WAIT_W`, 3, width of each per-source wait-state count.
- `IDLE_DATA`, 8'h00, value loaded on reset (Z80 NOP).

Ports (one clock; reset is synchronous and active-high):
- `pll0_250MHz  in  1` — system clock; all logic is on its rising edge.
- `reset  in  1` — synchronous, active-high reset.
- `src_data  in  NUM_SRC*DATA_W` — packed source data; source i occupies `[i*DATA_W +: DATA_W]`.
- `src_cs  in  NUM_SRC` — per-source select.
- `src_wait  in  NUM_SRC*WAIT_W` — per-source wait-state count, static configuration.
- `coll_clr  in  1` — clears the collision flag and counter.
- `out_data  out  DATA_W` — CPU data-in bus.
- `out_valid  out  1` — `out_data` belongs to the current locked transaction.
- `cpu_ready  out  1` — low inserts a CPU wait state.
- `active_idx  out  $clog2(NUM_SRC)` — locked source index.
- `collision  out  1` — sticky collision flag.
- `coll_count  out  16` — saturating collision count; present only with the macro.

## Operation
- **States:** IDLE, WAIT, VALID. All outputs are registered.
- **IDLE:**
  - `out_valid`=0, `cpu_ready`=1, `out_data` holds its last value.
  - If any `src_cs` is high, the lowest set index w wins. Latch `active_idx`=w and sample `src_wait[w]`=k.
  - k==0: load `src_data[w]` and go to VALID.
  - k>0: load the counter with k and go to WAIT.
- **WAIT:**
  - `cpu_ready`=0; the counter decrements each cycle.
  - When the counter reaches 1, load `src_data[w]`, go to VALID, and drive `cpu_ready`=1.
  - If `src_cs[w]` drops, abort to IDLE: `out_valid`=0, `cpu_ready`=1, `out_data` unchanged.
- **VALID:**
  - `out_valid`=1, `cpu_ready`=1.
  - `out_data` re-samples `src_data[w]` every cycle while `src_cs[w]` stays high.
  - When `src_cs[w]` drops, go to IDLE next cycle with `out_data` held.
  - Higher-priority selects never pre-empt a locked transaction.
- **Collision event:**
  - Occurs when more than one `src_cs` is high in the arbitration cycle, or any non-locked `src_cs` is high during WAIT or VALID.
  - At most one event is counted per transaction.
  - An event sets `collision`. If `coll_clr` and an event occur in the same cycle, the flag ends at 1 and the count ends at 1.
- **Reset values:** state IDLE, `out_data`=`IDLE_DATA`, `out_valid`=0, `cpu_ready`=1, `active_idx`=0, `collision`=0, `coll_count`=0.
- **Reset mid-transaction:** abandons the transaction immediately, with no partial update.
- **Select and wait-count changes:** `src_cs` rising in the same cycle a transaction ends in IDLE is arbitrated on the following cycle. `src_wait` is sampled only at arbitration.

## Timing
- Select first high at cycle N, k==0: data and `out_valid` appear at N+1 (one-cycle registered latency).
- k>0: `cpu_ready` is low for cycles N+1..N+k. Data and `out_valid` appear at N+k+1.
- Locked `cs` falls at cycle M: `out_valid`=0 at M+1.
- Back-to-back transactions need one IDLE cycle between them.
- `coll_count` saturates at 16'hFFFF and does not wrap.

## Configuration
- Macro: `CPU_DI_COLL_CNT_EN`.
- Defined: the 16-bit saturating `coll_count` register and port exist, and `coll_clr` clears them.
- Undefined: the port and counter are absent. Only the sticky `collision` flag remains, and `coll_clr` clears only the flag.

## Structure
- Package `cpu_di_pkg`:
  - state enum `{IDLE, WAIT, VALID}`
  - `IDX_W` = `$clog2(NUM_SRC)` helper
  - `NOP_DATA` = 8'h00
  - the count width constant of 16
- Sub-module `cpu_di_prio_enc`: combinational lowest-index priority encoder. It outputs `any`, `idx`, and `multi` (popcount > 1). It is instantiated once.

## Test plan
- Reset with `src_cs`=0 -> `out_data`=8'h00, `out_valid`=0, `cpu_ready`=1, `collision`=0.
- `src_cs`=10'b0000000100, `src_data[2]`=8'hA5, wait 0 -> `out_data`=8'hA5, `out_valid`=1 one cycle later, `active_idx`=2. `src_data[2]` changes to 8'h3C while selected -> output follows next cycle.
- Source 1 with wait 3, data 8'h7E -> `cpu_ready` low for exactly 3 cycles, 8'h7E valid on cycle 4. Dropping `cs` after 2 wait cycles -> abort, `cpu_ready`=1, `out_valid`=0, `out_data` unchanged.
- `src_cs`=10'b0000010010 at arbitration -> source 1 wins and `collision`=1. Raising `cs[0]` during VALID -> no pre-emption and no second count.
- With `CPU_DI_COLL_CNT_EN`: 3 colliding transactions -> `coll_count`=3. `coll_clr` together with a 4th collision -> count=1, flag=1. Forced count 16'hFFFF plus one more collision -> stays 16'hFFFF.
- Assert `reset` during WAIT -> next cycle all outputs at reset values. Subsequent clean select works normally.
